// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, functs, ALU ops,
// FSM states, pc_src / ld_size encodings and the opcode-class decoder.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_e;

  typedef enum logic [2:0] {
    CL_ILL, CL_R, CL_ADDIU, CL_BEQ, CL_BNE, CL_J, CL_LOAD, CL_STORE
  } class_e;

  // Latched per-instruction info: class, access size, load sign extension.
  typedef struct packed {
    class_e     cls;
    logic [1:0] size;
    logic       sgn;
  } op_info_t;

  // Map an opcode to its class; sub-word memory ops are illegal when disabled.
  function automatic op_info_t decode_op(input logic [5:0] op, input logic subword_en);
    op_info_t info;
    info.cls  = CL_ILL;
    info.size = LD_WORD;
    info.sgn  = 1'b0;
    case (op)
      OP_RTYPE: info.cls = CL_R;
      OP_J:     info.cls = CL_J;
      OP_BEQ:   info.cls = CL_BEQ;
      OP_BNE:   info.cls = CL_BNE;
      OP_ADDIU: info.cls = CL_ADDIU;
      OP_LW:    info.cls = CL_LOAD;
      OP_SW:    info.cls = CL_STORE;
      OP_LB:    if (subword_en) begin info.cls = CL_LOAD;  info.size = LD_BYTE; info.sgn = 1'b1; end
      OP_LBU:   if (subword_en) begin info.cls = CL_LOAD;  info.size = LD_BYTE; end
      OP_LH:    if (subword_en) begin info.cls = CL_LOAD;  info.size = LD_HALF; info.sgn = 1'b1; end
      OP_LHU:   if (subword_en) begin info.cls = CL_LOAD;  info.size = LD_HALF; end
      OP_SB:    if (subword_en) begin info.cls = CL_STORE; info.size = LD_BYTE; end
      OP_SH:    if (subword_en) begin info.cls = CL_STORE; info.size = LD_HALF; end
      default:  info.cls = CL_ILL;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decode.sv
// Combinational ALU-operation decode from opcode class and funct field.
module alu_decode
  import multicycle_control_pkg::*;
(
  input  class_e     cls,
  input  logic [5:0] funct,
  output logic [3:0] ct_alu,
  output logic       funct_illegal
);

  // R-type uses funct; branches compare by subtraction; everything else adds.
  always_comb begin
    ct_alu        = ALU_ADD;
    funct_illegal = 1'b0;
    case (cls)
      CL_R: begin
        case (funct)
          F_ADDU:  ct_alu = ALU_ADD;
          F_SUBU:  ct_alu = ALU_SUB;
          F_AND:   ct_alu = ALU_AND;
          F_OR:    ct_alu = ALU_OR;
          F_SLT:   ct_alu = ALU_SLT;
          default: funct_illegal = 1'b1;
        endcase
      end
      CL_BEQ, CL_BNE: ct_alu = ALU_SUB;
      default:        ct_alu = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM (IF/ID/EX/MEM/WB) with memory-wait timeout.
// Memory handshake: mem_req is held high until a cycle in which mem_ready is
// also high; that cycle completes the transfer. mem_ready while mem_req is low
// is ignored.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit SUBWORD_EN = 1'b1,
  parameter int WAIT_MAX   = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic [1:0] addr_lo,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_wen,
  output logic       mem_isrc,
  output logic [3:0] mem_wstrb,
  output logic       ir_wen,
  output logic       pc_wen,
  output logic [1:0] pc_src,
  output logic       rf_wen,
  output logic       rf_dst,
  output logic       alu_src,
  output logic       data_rf,
  output logic [3:0] ct_alu,
  output logic [1:0] ld_size,
  output logic       ld_signed,
  output logic       retire,
  output logic       exc_illegal,
  output logic       exc_misalign,
  output logic       exc_bus,
  output state_e     dbg_state
);

  localparam int WW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  state_e        state_q, state_d;
  op_info_t      info_q, info_d;
  logic [WW-1:0] wait_q, wait_d;

  op_info_t   dec;
  class_e     alu_cls;
  logic [3:0] alu_op;
  logic       funct_ill;
  logic       misalign;
  logic       timeout;
  logic [3:0] strobes;

  assign dec       = decode_op(op, SUBWORD_EN);
  // In ID the class register is not loaded yet, so decode straight from op.
  assign alu_cls   = (state_q == S_ID) ? dec.cls : info_q.cls;
  assign timeout   = (WAIT_MAX > 0) && (wait_q == WW'(WAIT_MAX));
  assign misalign  = ((info_q.size == LD_WORD) && (addr_lo != 2'b00)) ||
                     ((info_q.size == LD_HALF) && addr_lo[0]);
  assign dbg_state = state_q;

  alu_decode u_alu_decode (
    .cls           (alu_cls),
    .funct         (funct),
    .ct_alu        (alu_op),
    .funct_illegal (funct_ill)
  );

  // Byte strobes for the latched store size at the current address.
  always_comb begin
    strobes = 4'b0000;
    case (info_q.size)
      LD_WORD: strobes = 4'b1111;
      LD_HALF: strobes = 4'b0011 << {addr_lo[1], 1'b0};
      default: strobes = 4'b0001 << addr_lo;
    endcase
  end

  // State, class and wait-counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IF;
      info_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      info_q  <= info_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state and output decode from state plus latched class.
  always_comb begin
    state_d      = state_q;
    info_d       = info_q;
    wait_d       = wait_q;
    mem_req      = 1'b0;
    mem_wen      = 1'b0;
    mem_isrc     = 1'b0;
    mem_wstrb    = 4'b0000;
    ir_wen       = 1'b0;
    pc_wen       = 1'b0;
    pc_src       = PC_PLUS4;
    rf_wen       = 1'b0;
    rf_dst       = 1'b0;
    alu_src      = 1'b0;
    data_rf      = 1'b0;
    ct_alu       = 4'b0000;
    ld_size      = LD_BYTE;
    ld_signed    = 1'b0;
    retire       = 1'b0;
    exc_illegal  = 1'b0;
    exc_misalign = 1'b0;
    exc_bus      = 1'b0;
    case (state_q)
      S_IF: begin
        mem_isrc = 1'b1;
        if (timeout) begin
          exc_bus = 1'b1;
        end else begin
          mem_req = 1'b1;
          // Reset keeps the fetch request visible but must not load IR/PC.
          if (mem_ready && !reset) begin
            ir_wen  = 1'b1;
            pc_wen  = 1'b1;
            state_d = S_ID;
          end
        end
      end
      S_ID: begin
        info_d = dec;
        if (dec.cls == CL_ILL || (dec.cls == CL_R && funct_ill)) begin
          exc_illegal = 1'b1;
          state_d     = S_IF;
        end else if (dec.cls == CL_J) begin
          pc_wen  = 1'b1;
          pc_src  = PC_JUMP;
          retire  = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        ct_alu = alu_op;
        case (info_q.cls)
          CL_BEQ, CL_BNE: begin
            pc_wen  = alu_zero ^ (info_q.cls == CL_BNE);
            pc_src  = PC_BRANCH;
            retire  = 1'b1;
            state_d = S_IF;
          end
          CL_R:     state_d = S_WB;
          CL_ADDIU: begin alu_src = 1'b1; state_d = S_WB; end
          CL_LOAD, CL_STORE: begin alu_src = 1'b1; state_d = S_MEM; end
          default:  state_d = S_IF;
        endcase
      end
      S_MEM: begin
        // Misalignment is caught on the first MEM cycle, before any request.
        if (misalign) begin
          exc_misalign = 1'b1;
          state_d      = S_IF;
        end else if (timeout) begin
          exc_bus = 1'b1;
          state_d = S_IF;
        end else begin
          mem_req = 1'b1;
          if (info_q.cls == CL_STORE) begin
            mem_wen   = 1'b1;
            mem_wstrb = strobes;
          end
          if (mem_ready) begin
            if (info_q.cls == CL_STORE) begin
              retire  = 1'b1;
              state_d = S_IF;
            end else begin
              state_d = S_WB;
            end
          end
        end
      end
      S_WB: begin
        rf_wen = 1'b1;
        rf_dst = (info_q.cls == CL_R);
        if (info_q.cls == CL_LOAD) begin
          data_rf   = 1'b1;
          ld_size   = info_q.size;
          ld_signed = info_q.sgn;
        end
        retire  = 1'b1;
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
    // Wait counter: clears on any state change or timeout, else counts stalls.
    if (state_d != state_q || timeout) begin
      wait_d = '0;
    end else if ((WAIT_MAX > 0) && mem_req && !mem_ready) begin
      wait_d = wait_q + WW'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control: per-cycle state trace scoreboard
// plus hand-computed checks of control outputs.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [5:0] op, funct;
  logic alu_zero, mem_ready;
  logic [1:0] addr_lo;

  logic mem_req, mem_wen, mem_isrc, ir_wen, pc_wen, rf_wen, rf_dst, alu_src, data_rf;
  logic ld_signed, retire, exc_illegal, exc_misalign, exc_bus;
  logic [3:0] mem_wstrb, ct_alu;
  logic [1:0] pc_src, ld_size;
  state_e dbg_state;

  logic ns_mem_req, ns_mem_wen, ns_mem_isrc, ns_ir_wen, ns_pc_wen, ns_rf_wen, ns_rf_dst;
  logic ns_alu_src, ns_data_rf, ns_ld_signed, ns_retire, ns_exc_illegal, ns_exc_misalign, ns_exc_bus;
  logic [3:0] ns_mem_wstrb, ns_ct_alu;
  logic [1:0] ns_pc_src, ns_ld_size;
  state_e ns_dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int retire_cnt = 0;
  logic [2:0] exp_q[$];

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, got %0d compared", n_cmp);
    $fatal(1);
  end

  multicycle_control #(.SUBWORD_EN(1'b1), .WAIT_MAX(15)) u_dut (
    .clock(clock), .reset(reset), .op(op), .funct(funct), .alu_zero(alu_zero),
    .addr_lo(addr_lo), .mem_ready(mem_ready), .mem_req(mem_req), .mem_wen(mem_wen),
    .mem_isrc(mem_isrc), .mem_wstrb(mem_wstrb), .ir_wen(ir_wen), .pc_wen(pc_wen),
    .pc_src(pc_src), .rf_wen(rf_wen), .rf_dst(rf_dst), .alu_src(alu_src),
    .data_rf(data_rf), .ct_alu(ct_alu), .ld_size(ld_size), .ld_signed(ld_signed),
    .retire(retire), .exc_illegal(exc_illegal), .exc_misalign(exc_misalign),
    .exc_bus(exc_bus), .dbg_state(dbg_state)
  );

  multicycle_control #(.SUBWORD_EN(1'b0), .WAIT_MAX(15)) u_dut_ns (
    .clock(clock), .reset(reset), .op(op), .funct(funct), .alu_zero(alu_zero),
    .addr_lo(addr_lo), .mem_ready(mem_ready), .mem_req(ns_mem_req), .mem_wen(ns_mem_wen),
    .mem_isrc(ns_mem_isrc), .mem_wstrb(ns_mem_wstrb), .ir_wen(ns_ir_wen), .pc_wen(ns_pc_wen),
    .pc_src(ns_pc_src), .rf_wen(ns_rf_wen), .rf_dst(ns_rf_dst), .alu_src(ns_alu_src),
    .data_rf(ns_data_rf), .ct_alu(ns_ct_alu), .ld_size(ns_ld_size), .ld_signed(ns_ld_signed),
    .retire(ns_retire), .exc_illegal(ns_exc_illegal), .exc_misalign(ns_exc_misalign),
    .exc_bus(ns_exc_bus), .dbg_state(ns_dbg_state)
  );

  // Count retire pulses of the main instance
  always @(negedge clock) if (retire === 1'b1) retire_cnt <= retire_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive mem_ready for this cycle, sample at negedge and check the state trace
  task automatic cyc(input logic rdy);
    logic [2:0] e;
    mem_ready = rdy;
    @(negedge clock);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL state_trace: no expected state queued, got %0d", dbg_state);
    end else begin
      e = exp_q.pop_front();
      check("state", dbg_state, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_instr(input logic [5:0] o, input logic [5:0] f, input logic z, input logic [1:0] a);
    op = o; funct = f; alu_zero = z; addr_lo = a;
  endtask

  initial begin
    op = '0; funct = '0; alu_zero = 1'b0; addr_lo = '0; mem_ready = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_state", dbg_state, S_IF);
    check("rst_mem_req", mem_req, 1);
    check("rst_mem_isrc", mem_isrc, 1);
    mem_ready = 1'b1;
    #1;
    check("rst_ir_wen", ir_wen, 0);
    check("rst_pc_wen", pc_wen, 0);
    check("rst_retire", retire, 0);
    tick();
    check("rst_hold_if", dbg_state, S_IF);
    reset = 1'b0;

    // lb (signed byte load); the SUBWORD_EN=0 copy must flag it illegal
    set_instr(OP_LB, 6'd0, 1'b0, 2'b01);
    exp_q = '{S_IF, S_ID, S_EX, S_MEM, S_WB};
    cyc(1); check("lb_ir_wen", ir_wen, 1); check("lb_pc_wen", pc_wen, 1); check("lb_pc_src", pc_src, PC_PLUS4); tick();
    cyc(0); check("lb_ns_illegal", ns_exc_illegal, 1); check("lb_illegal", exc_illegal, 0); tick();
    cyc(0); check("lb_ns_back_if", ns_dbg_state, S_IF); check("lb_alu_src", alu_src, 1); check("lb_ct_alu", ct_alu, ALU_ADD); tick();
    cyc(1); check("lb_mem_req", mem_req, 1); check("lb_isrc", mem_isrc, 0); check("lb_wen", mem_wen, 0); check("lb_wstrb", mem_wstrb, 4'b0000); tick();
    cyc(0); check("lb_data_rf", data_rf, 1); check("lb_ld_size", ld_size, LD_BYTE); check("lb_ld_signed", ld_signed, 1);
    check("lb_rf_dst", rf_dst, 0); check("lb_retire", retire, 1); tick();

    // addu, zero wait: IF ID EX WB
    set_instr(OP_RTYPE, F_ADDU, 1'b0, 2'b00);
    exp_q = '{S_IF, S_ID, S_EX, S_WB};
    cyc(1); tick();
    cyc(0); check("addu_illegal", exc_illegal, 0); tick();
    cyc(0); check("addu_ct_alu", ct_alu, ALU_ADD); check("addu_alu_src", alu_src, 0); check("addu_mem_req", mem_req, 0); tick();
    cyc(0); check("addu_rf_wen", rf_wen, 1); check("addu_rf_dst", rf_dst, 1); check("addu_data_rf", data_rf, 0); check("addu_retire", retire, 1); tick();

    // sb at addr_lo=10
    set_instr(OP_SB, 6'd0, 1'b0, 2'b10);
    exp_q = '{S_IF, S_ID, S_EX, S_MEM};
    cyc(1); tick(); cyc(0); tick(); cyc(0); tick();
    cyc(1); check("sb_wstrb", mem_wstrb, 4'b0100); check("sb_wen", mem_wen, 1); check("sb_req", mem_req, 1); check("sb_retire", retire, 1); tick();

    // sh at addr_lo=01: misaligned, no request; mem_ready there is ignored
    set_instr(OP_SH, 6'd0, 1'b0, 2'b01);
    exp_q = '{S_IF, S_ID, S_EX, S_MEM};
    cyc(1); tick(); cyc(0); tick(); cyc(0); tick();
    cyc(1); check("sh_misalign", exc_misalign, 1); check("sh_req", mem_req, 0); check("sh_wen", mem_wen, 0); check("sh_retire", retire, 0); tick();

    // bne with alu_zero=0: taken
    set_instr(OP_BNE, 6'd0, 1'b0, 2'b00);
    exp_q = '{S_IF, S_ID, S_EX};
    cyc(1); tick(); cyc(0); tick();
    cyc(0); check("bne_pc_wen", pc_wen, 1); check("bne_pc_src", pc_src, PC_BRANCH); check("bne_ct_alu", ct_alu, ALU_SUB); check("bne_retire", retire, 1); tick();

    // beq with alu_zero=0: not taken, still retires
    set_instr(OP_BEQ, 6'd0, 1'b0, 2'b00);
    exp_q = '{S_IF, S_ID, S_EX};
    cyc(1); tick(); cyc(0); tick();
    cyc(0); check("beq0_pc_wen", pc_wen, 0); check("beq0_retire", retire, 1); tick();

    // beq with alu_zero=1: taken
    set_instr(OP_BEQ, 6'd0, 1'b1, 2'b00);
    exp_q = '{S_IF, S_ID, S_EX};
    cyc(1); tick(); cyc(0); tick();
    cyc(0); check("beq1_pc_wen", pc_wen, 1); check("beq1_retire", retire, 1); tick();

    // j: retires from ID
    set_instr(OP_J, 6'd0, 1'b0, 2'b00);
    exp_q = '{S_IF, S_ID};
    cyc(1); tick();
    cyc(0); check("j_pc_wen", pc_wen, 1); check("j_pc_src", pc_src, PC_JUMP); check("j_retire", retire, 1); tick();

    // lw with mem_ready delayed 3 cycles: 8 cycles total
    set_instr(OP_LW, 6'd0, 1'b0, 2'b00);
    exp_q = '{S_IF, S_ID, S_EX, S_MEM, S_MEM, S_MEM, S_MEM, S_WB};
    cyc(1); tick(); cyc(0); tick(); cyc(0); tick();
    for (int i = 0; i < 3; i++) begin
      cyc(0); check("lw_wait_req", mem_req, 1); check("lw_wait_retire", retire, 0); tick();
    end
    cyc(1); check("lw_done_req", mem_req, 1); tick();
    cyc(0); check("lw_data_rf", data_rf, 1); check("lw_ld_size", ld_size, LD_WORD); check("lw_ld_signed", ld_signed, 0); check("lw_retire", retire, 1); tick();

    // Fetch timeout: 15 wait cycles, then exc_bus, then a normal re-fetch
    set_instr(OP_RTYPE, F_ADDU, 1'b0, 2'b00);
    for (int i = 0; i < 16; i++) exp_q.push_back(S_IF);
    exp_q.push_back(S_IF); exp_q.push_back(S_ID); exp_q.push_back(S_EX); exp_q.push_back(S_WB);
    for (int i = 0; i < 15; i++) begin
      cyc(0); check("to_wait_req", mem_req, 1); check("to_wait_bus", exc_bus, 0); tick();
    end
    cyc(0); check("to_bus", exc_bus, 1); check("to_req_drop", mem_req, 0); tick();
    cyc(1); check("to_refetch_bus", exc_bus, 0); check("to_refetch_ir", ir_wen, 1); tick();
    cyc(0); tick(); cyc(0); tick();
    cyc(0); check("to_addu_retire", retire, 1); tick();

    // Illegal funct, then illegal opcode
    set_instr(OP_RTYPE, 6'b000000, 1'b0, 2'b00);
    exp_q = '{S_IF, S_ID};
    cyc(1); tick();
    cyc(0); check("ill_funct", exc_illegal, 1); check("ill_funct_retire", retire, 0); tick();
    set_instr(6'b111111, 6'd0, 1'b0, 2'b00);
    exp_q = '{S_IF, S_ID};
    cyc(1); tick();
    cyc(0); check("ill_op", exc_illegal, 1); tick();

    // Reset during a MEM wait of sw, then a normal addu
    set_instr(OP_SW, 6'd0, 1'b0, 2'b00);
    exp_q = '{S_IF, S_ID, S_EX, S_MEM, S_MEM};
    cyc(1); tick(); cyc(0); tick(); cyc(0); tick();
    cyc(0); check("sw_wen", mem_wen, 1); check("sw_wstrb", mem_wstrb, 4'b1111); tick();
    cyc(0); check("sw_req", mem_req, 1); tick();
    reset = 1'b1;
    #1;
    check("mrst_state", dbg_state, S_IF);
    check("mrst_wen", mem_wen, 0);
    check("mrst_retire", retire, 0);
    check("mrst_isrc", mem_isrc, 1);
    tick();
    reset = 1'b0;
    check("trace_drained", exp_q.size(), 0);
    set_instr(OP_RTYPE, F_ADDU, 1'b0, 2'b00);
    exp_q = '{S_IF, S_ID, S_EX, S_WB};
    cyc(1); check("post_rst_ir", ir_wen, 1); tick();
    cyc(0); tick(); cyc(0); tick();
    cyc(0); check("post_rst_retire", retire, 1); tick();

    // Total retires: lb, addu, sb, bne, beq, beq, j, lw, addu, addu
    check("retire_total", retire_cnt, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
